// File: rtl/sprite_ram_pkg.sv
// ============================================================================
// sprite_ram_pkg
// Shared widths, address-space limit, background palette and the enums used
// by the sprite frame-RAM arbiter and its round-robin sub-arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package sprite_ram_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 4;

  // First address outside the populated sprite sheet.
  localparam logic [ADDR_W-1:0] SS_DEPTH = 16'd40000;

  // Palette ID returned for reads that do not touch the RAM.
  localparam logic [DATA_W-1:0] BG_PALETTE = 4'h0;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Which requester owns the read data returning next cycle.
  typedef enum logic [1:0] {
    NONE  = 2'd0,
    DISP  = 2'd1,
    PROBE = 2'd2
  } owner_t;

  function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr);
    return addr < SS_DEPTH;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// rr_arb2
// Two-requester round-robin arbiter. Grants are combinational; a registered
// last-winner bit makes the previous winner lose the next tie. A lone
// requester always wins immediately.
//
// Ports:
//   clk          clock
//   rst_n        synchronous active-low reset (pointer -> requester A first)
//   req_a/req_b  requests
//   gnt_a/gnt_b  one-hot-or-zero grants
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b
);

  // 1 when B won the most recent grant, so A wins the next tie.
  logic last_b;

  assign gnt_a = req_a & (~req_b | last_b);
  assign gnt_b = req_b & (~req_a | ~last_b);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_b <= 1'b1;
    end else if (gnt_a | gnt_b) begin
      last_b <= gnt_b;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sprite_ram.sv


// File: rtl/sprite_ram_arbiter.sv
// ============================================================================
// sprite_ram_arbiter
// Arbitrates a single frame-RAM port between the display pipeline (absolute
// priority), game-logic collision probes and a sprite-sheet loader. Reads
// return one cycle after the grant; out-of-range reads return BG_PALETTE and
// out-of-range writes are granted but suppressed.
//
// Build option: define SPRITE_RAM_LOADER_EN to include the BOOT state, the
// loader write path and the loader leg of the round robin. Without it the
// block comes out of reset in RUN and the probe is the only secondary
// requester.
//
// Ports:
//   Clk, Reset_n                   clock, synchronous active-low reset
//   disp_req/disp_addr             display read request
//   disp_data/disp_valid           display read result
//   pr_req/pr_addr                 probe read request
//   pr_gnt/pr_data/pr_valid        probe grant and read result
//   ld_req/ld_addr/ld_wdata        loader write request
//   ld_done                        loader finished pulse
//   ld_gnt                         loader grant
//   ram_addr/ram_we/ram_wdata      frame RAM request (combinational)
//   ram_rdata                      frame RAM read data (1-cycle latency)
//   ready                          arbiter in RUN
//   starve                         probe starved for STARVE_LIMIT cycles
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sprite_ram_arbiter
  import sprite_ram_pkg::*;
#(
  parameter int STARVE_LIMIT = 1024
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_data,
  output logic              disp_valid,
  input  logic              pr_req,
  input  logic [ADDR_W-1:0] pr_addr,
  output logic              pr_gnt,
  output logic [DATA_W-1:0] pr_data,
  output logic              pr_valid,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  input  logic              ld_done,
  output logic              ld_gnt,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ready,
  output logic              starve
);

  localparam int              CNT_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

`ifdef SPRITE_RAM_LOADER_EN
  localparam state_t RESET_STATE = BOOT;
`else
  localparam state_t RESET_STATE = RUN;
`endif

  // --------------------------------------------------------------------------
  // Boot/run state machine
  // --------------------------------------------------------------------------
  state_t state;
  state_t state_next;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= RESET_STATE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
`ifdef SPRITE_RAM_LOADER_EN
    if (state == BOOT && ld_done) begin
      state_next = RUN;
    end
`endif
  end

  // Low during the reset cycle and for the first edge after it, so ready
  // rises one cycle after reset release even when the FSM resets into RUN.
  logic alive;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      alive <= 1'b0;
    end else begin
      alive <= 1'b1;
    end
  end

  // Reset_n gates everything combinational so no grant or strobe can leak
  // out while reset is held.
  logic in_run;
  logic in_boot;

  assign in_run  = Reset_n && (state == RUN);
  assign in_boot = Reset_n && (state == BOOT);

  // --------------------------------------------------------------------------
  // Arbitration
  // --------------------------------------------------------------------------
  logic disp_own;
  logic pr_arb_req;
  logic ld_arb_req;
  logic pr_win;
  logic ld_win;

  assign disp_own   = in_run && disp_req;
  assign pr_arb_req = in_run && !disp_req && pr_req;
`ifdef SPRITE_RAM_LOADER_EN
  assign ld_arb_req = in_run && !disp_req && ld_req;
`else
  assign ld_arb_req = 1'b0;
`endif

  rr_arb2 u_rr_arb2 (
    .clk   (Clk),
    .rst_n (Reset_n),
    .req_a (pr_arb_req),
    .req_b (ld_arb_req),
    .gnt_a (pr_win),
    .gnt_b (ld_win)
  );

  assign pr_gnt = pr_win;

`ifdef SPRITE_RAM_LOADER_EN
  // In BOOT the loader is the only RAM user, so it bypasses the round robin
  // and does not disturb the pointer.
  assign ld_gnt = ld_win | (in_boot && ld_req);
`else
  assign ld_gnt = 1'b0;

  logic unused_loader;
  assign unused_loader = ^{ld_req, ld_addr, ld_wdata, ld_done, ld_win};
`endif

  // --------------------------------------------------------------------------
  // RAM port mux
  // --------------------------------------------------------------------------
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (disp_own) begin
      ram_addr = disp_addr;
    end else if (pr_win) begin
      ram_addr = pr_addr;
    end
`ifdef SPRITE_RAM_LOADER_EN
    else if (ld_gnt) begin
      ram_addr  = ld_addr;
      ram_wdata = ld_wdata;
      ram_we    = addr_in_range(ld_addr);
    end
`endif
  end

  // --------------------------------------------------------------------------
  // Read tag: who owns next cycle's ram_rdata, and whether to substitute
  // the background palette instead.
  // --------------------------------------------------------------------------
  owner_t rd_owner;
  owner_t rd_owner_next;
  logic   rd_bg;
  logic   rd_bg_next;

  always_comb begin
    rd_owner_next = NONE;
    rd_bg_next    = 1'b0;
    if (disp_own) begin
      rd_owner_next = DISP;
      rd_bg_next    = !addr_in_range(disp_addr);
    end else if (in_boot && disp_req) begin
      // Sheet is not loaded yet: answer without touching the RAM.
      rd_owner_next = DISP;
      rd_bg_next    = 1'b1;
    end else if (pr_win) begin
      rd_owner_next = PROBE;
      rd_bg_next    = !addr_in_range(pr_addr);
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rd_owner <= NONE;
      rd_bg    <= 1'b0;
    end else begin
      rd_owner <= rd_owner_next;
      rd_bg    <= rd_bg_next;
    end
  end

  assign disp_valid = Reset_n && (rd_owner == DISP);
  assign pr_valid   = Reset_n && (rd_owner == PROBE);
  assign disp_data  = (disp_valid && !rd_bg) ? ram_rdata : BG_PALETTE;
  assign pr_data    = (pr_valid && !rd_bg) ? ram_rdata : BG_PALETTE;

  // --------------------------------------------------------------------------
  // Probe starvation counter
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] starve_cnt;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      starve_cnt <= '0;
    end else if (state != RUN) begin
      starve_cnt <= '0;
    end else if (pr_req && !pr_win) begin
      if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  assign starve = Reset_n && (starve_cnt == CNT_MAX);
  assign ready  = Reset_n && alive && (state == RUN);

endmodule

`default_nettype wire
